// File: rtl/mlp_sequencer.sv
// Control sequencer for a two-layer MLP on a shared MAC: drives ROM/RAM addresses and MAC
// strobes, adds bias with 16-bit saturation, applies ReLU on hidden writes and tracks output argmax.
module mlp_sequencer #(
   parameter int N_IN       = 4,
   parameter int N_HID      = 3,
   parameter int N_OUT      = 2,
   parameter int MAC_LAT    = 1,
   parameter int AUTO_START = 1,
   parameter int AW         = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   output logic               busy,
   output logic               finished,
   output logic [AW-1:0]      w_addr,
   output logic [AW-1:0]      b_addr,
   output logic [AW-1:0]      x_addr,
   output logic               x_sel,
   output logic               mac_clr,
   output logic               mac_en,
   input  logic signed [15:0] mac_acc,
   input  logic signed [15:0] bias,
   output logic               h_we,
   output logic [AW-1:0]      h_waddr,
   output logic [15:0]        h_wdata,
   output logic               y_we,
   output logic [AW-1:0]      y_waddr,
   output logic [15:0]        y_wdata,
   output logic [15:0]        out
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_ISSUE,
      S_DRAIN,
      S_WRITE,
      S_DONE
   } state_t;

   localparam logic [AW-1:0] L0_FAN_LAST = AW'(N_IN - 1);
   localparam logic [AW-1:0] L1_FAN_LAST = AW'(N_HID - 1);
   localparam logic [AW-1:0] L0_N_LAST   = AW'(N_HID - 1);
   localparam logic [AW-1:0] L1_N_LAST   = AW'(N_OUT - 1);
   localparam logic [AW-1:0] DRAIN_LAST  = AW'(MAC_LAT);
   localparam logic [AW-1:0] IN_A        = AW'(N_IN);
   localparam logic [AW-1:0] HID_A       = AW'(N_HID);
   localparam logic [AW-1:0] L1_W_BASE   = AW'(N_HID * N_IN);

   state_t             state_q, state_d;
   logic               layer_q, layer_d;
   logic [AW-1:0]      n_q, n_d;
   logic [AW-1:0]      k_q, k_d;
   logic [AW-1:0]      d_q, d_d;
   logic signed [15:0] acc_q, acc_d;
   logic signed [15:0] max_q, max_d;
   logic [AW-1:0]      idx_q, idx_d;
   logic [15:0]        out_q, out_d;
   logic               busy_q, busy_d;
   logic               fin_q, fin_d;
   logic               auto_q, auto_d;
   logic               mac_en_q, mac_en_d;

   logic [AW-1:0]      fan_last;
   logic [AW-1:0]      n_last;
   logic [16:0]        sum17;
   logic signed [15:0] sat_s;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         layer_q  <= 1'b0;
         n_q      <= '0;
         k_q      <= '0;
         d_q      <= '0;
         acc_q    <= '0;
         max_q    <= '0;
         idx_q    <= '0;
         out_q    <= '0;
         busy_q   <= 1'b0;
         fin_q    <= 1'b0;
         auto_q   <= (AUTO_START != 0);
         mac_en_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         layer_q  <= layer_d;
         n_q      <= n_d;
         k_q      <= k_d;
         d_q      <= d_d;
         acc_q    <= acc_d;
         max_q    <= max_d;
         idx_q    <= idx_d;
         out_q    <= out_d;
         busy_q   <= busy_d;
         fin_q    <= fin_d;
         auto_q   <= auto_d;
         mac_en_q <= mac_en_d;
      end
   end

   // Bias add is done one bit wider so overflow shows up as a sign disagreement.
   always_comb begin
      sum17 = {acc_q[15], acc_q} + {bias[15], bias};
      sat_s = sum17[15:0];
      if (sum17[16] != sum17[15]) begin
         sat_s = sum17[16] ? 16'sh8000 : 16'sh7FFF;
      end
   end

   always_comb begin
      state_d  = state_q;
      layer_d  = layer_q;
      n_d      = n_q;
      k_d      = k_q;
      d_d      = d_q;
      acc_d    = acc_q;
      max_d    = max_q;
      idx_d    = idx_q;
      out_d    = out_q;
      busy_d   = busy_q;
      fin_d    = fin_q;
      auto_d   = auto_q;
      mac_en_d = 1'b0;

      w_addr   = '0;
      b_addr   = '0;
      x_addr   = '0;
      x_sel    = 1'b0;
      mac_clr  = 1'b0;
      h_we     = 1'b0;
      h_waddr  = '0;
      h_wdata  = '0;
      y_we     = 1'b0;
      y_waddr  = '0;
      y_wdata  = '0;

      fan_last = layer_q ? L1_FAN_LAST : L0_FAN_LAST;
      n_last   = layer_q ? L1_N_LAST : L0_N_LAST;

      // Bias address is held from CLEAR through WRITE so the sync ROM output stays valid.
      if (state_q == S_CLEAR || state_q == S_ISSUE || state_q == S_DRAIN || state_q == S_WRITE) begin
         b_addr = layer_q ? (HID_A + n_q) : n_q;
      end

      case (state_q)
         S_IDLE: begin
            if (auto_q || start) begin
               state_d = S_CLEAR;
               busy_d  = 1'b1;
               fin_d   = 1'b0;
               layer_d = 1'b0;
               n_d     = '0;
               auto_d  = 1'b0;
            end
         end
         S_CLEAR: begin
            mac_clr = 1'b1;
            k_d     = '0;
            state_d = S_ISSUE;
         end
         S_ISSUE: begin
            mac_en_d = 1'b1;
            x_addr   = k_q;
            x_sel    = layer_q;
            w_addr   = layer_q ? (L1_W_BASE + n_q * HID_A + k_q) : (n_q * IN_A + k_q);
            if (k_q == fan_last) begin
               d_d     = '0;
               state_d = S_DRAIN;
            end else begin
               k_d = k_q + 1'b1;
            end
         end
         S_DRAIN: begin
            if (d_q == DRAIN_LAST) begin
               acc_d   = mac_acc;
               state_d = S_WRITE;
            end else begin
               d_d = d_q + 1'b1;
            end
         end
         S_WRITE: begin
            if (!layer_q) begin
               h_we    = !reset;
               h_waddr = n_q;
               h_wdata = sat_s[15] ? 16'h0000 : sat_s;
            end else begin
               y_we    = !reset;
               y_waddr = n_q;
               y_wdata = sat_s;
               if (n_q == '0 || sat_s > max_q) begin
                  max_d = sat_s;
                  idx_d = n_q;
               end
            end
            if (n_q != n_last) begin
               n_d     = n_q + 1'b1;
               state_d = S_CLEAR;
            end else if (!layer_q) begin
               layer_d = 1'b1;
               n_d     = '0;
               state_d = S_CLEAR;
            end else begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            out_d   = 16'(idx_q);
            busy_d  = 1'b0;
            fin_d   = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign busy     = busy_q;
   assign finished = fin_q;
   assign mac_en   = mac_en_q;
   assign out      = out_q;

endmodule

// File: tb/tb_mlp_sequencer.sv
// Bench for mlp_sequencer: behavioural ROMs, RAMs and a saturating MAC around the DUT,
// with expected hidden/output writes queued per run and checked as the DUT writes them.
module tb_mlp_sequencer;
   localparam int AW = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               reset = 1'b1;
   logic               start = 1'b0;
   logic               busy, finished, x_sel, mac_clr, mac_en, h_we, y_we;
   logic [AW-1:0]      w_addr, b_addr, x_addr, h_waddr, y_waddr;
   logic signed [15:0] mac_acc;
   logic signed [15:0] bias;
   logic [15:0]        h_wdata, y_wdata, out;

   mlp_sequencer dut (
      .clk(clk), .reset(reset), .start(start), .busy(busy), .finished(finished),
      .w_addr(w_addr), .b_addr(b_addr), .x_addr(x_addr), .x_sel(x_sel),
      .mac_clr(mac_clr), .mac_en(mac_en), .mac_acc(mac_acc), .bias(bias),
      .h_we(h_we), .h_waddr(h_waddr), .h_wdata(h_wdata),
      .y_we(y_we), .y_waddr(y_waddr), .y_wdata(y_wdata), .out(out)
   );

   logic signed [15:0] wrom [0:255];
   logic signed [15:0] brom [0:255];
   logic signed [15:0] xin  [0:15];
   logic signed [15:0] hram [0:15];
   logic signed [15:0] ovr  [0:15];
   logic [15:0]        y_last [0:1];
   bit                 ovr_en = 1'b0;
   logic signed [15:0] w_dat, x_dat;
   logic signed [15:0] acc = 16'sd0;

   function automatic logic signed [15:0] sat16(input int v);
      if (v > 32767) return 16'sh7FFF;
      if (v < -32768) return 16'sh8000;
      return 16'(v);
   endfunction

   always @(posedge clk) begin
      w_dat <= wrom[w_addr];
      bias  <= brom[b_addr];
      x_dat <= x_sel ? hram[x_addr[3:0]] : xin[x_addr[3:0]];
      if (h_we) hram[h_waddr[3:0]] <= h_wdata;
      if (mac_clr) acc <= 16'sd0;
      else if (mac_en) acc <= sat16(int'(acc) + ((int'(w_dat) * int'(x_dat)) >>> 8));
   end
   assign mac_acc = ovr_en ? ovr[b_addr[3:0]] : acc;

   typedef struct {
      bit         is_y;
      logic [7:0] addr;
      logic [15:0] data;
   } wr_t;

   wr_t         exp_q[$];
   wr_t         mon_e;
   logic [15:0] exp_out;
   int          vectors = 0;
   int          miscompares = 0;

   // Reference: straight dot products in Q8.8, bias add, clamp, ReLU on the hidden layer.
   task automatic push_run(input int limit);
      logic signed [15:0] h [0:2];
      logic signed [15:0] s;
      logic signed [15:0] ymax;
      int a, cnt, best;
      cnt = 0;
      best = 0;
      ymax = 16'sd0;
      for (int n = 0; n < 3; n++) begin
         a = 0;
         for (int k = 0; k < 4; k++) a += (int'(wrom[n*4+k]) * int'(xin[k])) >>> 8;
         if (ovr_en) a = int'(ovr[n]);
         s = sat16(a + int'(brom[n]));
         h[n] = (s < 0) ? 16'sd0 : s;
         if (cnt < limit) exp_q.push_back('{1'b0, 8'(n), 16'(h[n])});
         cnt++;
      end
      for (int n = 0; n < 2; n++) begin
         a = 0;
         for (int k = 0; k < 3; k++) a += (int'(wrom[12+n*3+k]) * int'(h[k])) >>> 8;
         if (ovr_en) a = int'(ovr[3+n]);
         s = sat16(a + int'(brom[3+n]));
         if (n == 0 || s > ymax) begin
            ymax = s;
            best = n;
         end
         if (cnt < limit) exp_q.push_back('{1'b1, 8'(n), 16'(s)});
         cnt++;
      end
      exp_out = 16'(best);
   endtask

   always @(negedge clk) begin
      if (h_we || y_we) begin
         vectors++;
         if (y_we) y_last[y_waddr[0]] = y_wdata;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL write_unexpected: got y=%0b addr %0d data %h, required no write",
                     y_we, y_we ? y_waddr : h_waddr, y_we ? y_wdata : h_wdata);
         end else begin
            mon_e = exp_q.pop_front();
            if (y_we !== mon_e.is_y || (y_we ? y_waddr : h_waddr) !== mon_e.addr ||
                (y_we ? y_wdata : h_wdata) !== mon_e.data) begin
               miscompares++;
               $display("FAIL write_data: got y=%0b addr %0d data %h, required y=%0b addr %0d data %h",
                        y_we, y_we ? y_waddr : h_waddr, y_we ? y_wdata : h_wdata,
                        mon_e.is_y, mon_e.addr, mon_e.data);
            end
         end
      end
   end

   task automatic load_t1();
      for (int i = 0; i < 256; i++) begin
         wrom[i] = 16'sh0100;
         brom[i] = 16'sh0000;
      end
      for (int i = 0; i < 16; i++) begin
         xin[i] = 16'sh0100;
         ovr[i] = 16'sh0000;
      end
      ovr_en = 1'b0;
   endtask

   task automatic do_start();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
   endtask

   // Called at the negedge after the accept edge; returns edges until finished, -1 on timeout.
   task automatic run_edges(output int edges);
      edges = -1;
      for (int i = 1; i <= 200; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (finished) begin
            edges = i;
            return;
         end
      end
   endtask

   task automatic test_reset();
      int e;
      load_t1();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      vectors++;
      if ({busy, finished, mac_clr, mac_en, h_we, y_we} !== 6'b0) begin
         miscompares++;
         $display("FAIL reset_ctrl: got %b, required 000000", {busy, finished, mac_clr, mac_en, h_we, y_we});
      end
      vectors++;
      if (out !== 16'h0000) begin
         miscompares++;
         $display("FAIL reset_out: got %h, required 0000", out);
      end
      vectors++;
      if ({w_addr, b_addr, x_addr, h_waddr, y_waddr} !== '0) begin
         miscompares++;
         $display("FAIL reset_addr: got %h %h %h, required all zero", w_addr, b_addr, x_addr);
      end
      push_run(99);
      reset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      vectors++;
      if ({busy, finished} !== 2'b10) begin
         miscompares++;
         $display("FAIL auto_start_busy: got busy/fin %b, required 10", {busy, finished});
      end
      run_edges(e);
      vectors++;
      if (e !== 39) begin
         miscompares++;
         $display("FAIL auto_run_edges: got %0d, required 39", e);
      end
      vectors++;
      if (out !== 16'h0000 || exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL auto_run_out: got out %h pending %0d, required out 0000 pending 0", out, exp_q.size());
      end
   endtask

   task automatic test_relu_bias();
      int e;
      load_t1();
      for (int i = 0; i < 3; i++) brom[i] = 16'shF800;
      brom[3] = 16'sh0080;
      brom[4] = 16'sh0140;
      push_run(99);
      do_start();
      vectors++;
      if ({busy, finished} !== 2'b10) begin
         miscompares++;
         $display("FAIL rerun_clears_finished: got busy/fin %b, required 10", {busy, finished});
      end
      run_edges(e);
      vectors++;
      if (e !== 39 || out !== 16'h0001 || exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL relu_run: got edges %0d out %h pending %0d, required 39 0001 0", e, out, exp_q.size());
      end
   endtask

   task automatic test_saturation();
      int e;
      load_t1();
      brom[0] = 16'sh7F00; ovr[0] = 16'sh7F00;
      brom[1] = 16'sh8100; ovr[1] = 16'sh8100;
      brom[2] = 16'sh0200; ovr[2] = 16'sh0100;
      brom[3] = 16'sh8100; ovr[3] = 16'sh8100;
      brom[4] = 16'sh7F00; ovr[4] = 16'sh7F00;
      ovr_en = 1'b1;
      push_run(99);
      do_start();
      run_edges(e);
      vectors++;
      if (hram[0] !== 16'sh7FFF || hram[1] !== 16'sh0000 || hram[2] !== 16'sh0300) begin
         miscompares++;
         $display("FAIL sat_hidden: got %h %h %h, required 7fff 0000 0300", hram[0], hram[1], hram[2]);
      end
      vectors++;
      if (y_last[0] !== 16'h8000 || y_last[1] !== 16'h7FFF) begin
         miscompares++;
         $display("FAIL sat_output: got %h %h, required 8000 7fff", y_last[0], y_last[1]);
      end
      vectors++;
      if (e !== 39 || out !== 16'h0001 || exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL sat_run: got edges %0d out %h pending %0d, required 39 0001 0", e, out, exp_q.size());
      end
      ovr_en = 1'b0;
   endtask

   task automatic test_argmax();
      int e;
      load_t1();
      for (int i = 0; i < 256; i++) wrom[i] = 16'sh0000;
      brom[3] = 16'sh0100;
      brom[4] = 16'sh0200;
      push_run(99);
      do_start();
      run_edges(e);
      vectors++;
      if (out !== 16'h0001 || exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL argmax_higher: got %h pending %0d, required 0001 0", out, exp_q.size());
      end
      brom[4] = 16'sh0100;
      push_run(99);
      do_start();
      run_edges(e);
      vectors++;
      if (out !== 16'h0000 || exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL argmax_tie: got %h pending %0d, required 0000 0", out, exp_q.size());
      end
   endtask

   task automatic test_start_ignored();
      int e;
      load_t1();
      push_run(99);
      do_start();
      e = -1;
      for (int i = 1; i <= 200; i++) begin
         start = (i == 10);
         @(posedge clk);
         @(negedge clk);
         if (finished) begin
            e = i;
            break;
         end
      end
      start = 1'b0;
      vectors++;
      if (e !== 39 || exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL start_while_busy: got edges %0d pending %0d, required 39 0", e, exp_q.size());
      end
      repeat (3) @(negedge clk);
      vectors++;
      if ({busy, finished} !== 2'b01) begin
         miscompares++;
         $display("FAIL idle_after_run: got busy/fin %b, required 01", {busy, finished});
      end
   endtask

   task automatic test_reset_midrun();
      int e;
      load_t1();
      push_run(2);
      do_start();
      for (int i = 1; i <= 20; i++) begin
         reset = (i == 20);
         @(posedge clk);
         @(negedge clk);
      end
      vectors++;
      if ({busy, finished} !== 2'b00 || out !== 16'h0000 || exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL reset_abort: got busy/fin %b out %h pending %0d, required 00 0000 0",
                  {busy, finished}, out, exp_q.size());
      end
      @(posedge clk);
      @(negedge clk);
      push_run(99);
      reset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      run_edges(e);
      vectors++;
      if (e !== 39 || out !== 16'h0000 || exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL reset_rerun: got edges %0d out %h pending %0d, required 39 0000 0", e, out, exp_q.size());
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got simulation still running, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_relu_bias();
      test_saturation();
      test_argmax();
      test_start_ignored();
      test_reset_midrun();
      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
